// File: rtl/add_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_checker_pkg
// Description : Shared types and sizing helpers for the add_checker BIST
//               engine.
// Revision    : 1.0 - initial release
// ============================================================================
package add_checker_pkg;

  // Checker control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Number of operand pairs an exhaustive run covers: 2^(2*width)
  function automatic int pair_count(input int width);
    return 1 << (2 * width);
  endfunction

  // Settle counter width; never narrower than one bit so SETTLE=1 still
  // has a legal (constant zero) counter
  function automatic int settle_cnt_width(input int settle);
    int w;
    w = $clog2(settle);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : add_checker_pkg
`default_nettype wire

// File: rtl/add_checker_opgen.sv
`default_nettype none
// ============================================================================
// Module      : add_checker_opgen
// Description : Operand pair counter. num2 is the fast digit, num1 the slow
//               one; last flags the final pair {max, max}.
// Revision    : 1.0 - initial release
// ============================================================================
module add_checker_opgen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  output logic [WIDTH-1:0] num1,
  output logic [WIDTH-1:0] num2,
  output logic             last
);

  localparam logic [WIDTH-1:0] OP_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] num1_q;
  logic [WIDTH-1:0] num2_q;

  // Two-digit counter: num2 counts every step, num1 counts on num2 wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num1_q <= '0;
      num2_q <= '0;
    end else if (clear) begin
      num1_q <= '0;
      num2_q <= '0;
    end else if (step) begin
      num2_q <= num2_q + 1'b1;
      if (num2_q == OP_MAX) begin
        num1_q <= num1_q + 1'b1;
      end
    end
  end

  assign num1 = num1_q;
  assign num2 = num2_q;
  assign last = (num1_q == OP_MAX) && (num2_q == OP_MAX);

endmodule : add_checker_opgen
`default_nettype wire

// File: rtl/add_checker.sv
`default_nettype none
// ============================================================================
// Module      : add_checker
// Description : Exhaustive built-in self-test for a WIDTH-bit adder. Sweeps
//               every operand pair, compares {cout,out} with the reference
//               sum, counts mismatches and captures the first failure.
// Revision    : 1.0 - initial release
// ============================================================================
module add_checker
  import add_checker_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int SETTLE = 1,
  localparam int ERR_W  = $clog2(pair_count(WIDTH)) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] num1,
  output logic [WIDTH-1:0] num2,
  input  logic [WIDTH-1:0] out_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH:0]   fail_got
);

  localparam int             CNT_W  = settle_cnt_width(SETTLE);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  // A zero-cycle settle window would sample the adder before it sees the
  // new operands, so it is rejected at elaboration
  if (SETTLE < 1) begin : g_bad_settle
    $error("add_checker: SETTLE must be >= 1");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             fail_valid_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic [WIDTH:0]   fail_got_q;

  logic             launch;
  logic             step;
  logic             last;
  logic [WIDTH:0]   expected;
  logic [WIDTH:0]   got;
  logic             mismatch;

  assign launch   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign step     = (state_q == ST_CHECK) && !last;
  assign expected = {1'b0, num1} + {1'b0, num2};
  assign got      = {cout_in, out_in};
  assign mismatch = (got != expected);
  assign err_d    = err_q + ERR_W'(mismatch);

  add_checker_opgen #(
    .WIDTH (WIDTH)
  ) u_opgen (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .step  (step),
    .num1  (num1),
    .num2  (num2),
    .last  (last)
  );

  // Run sequencing plus error accounting and first-failure capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_got_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_SETTLE;
            cnt_q        <= RELOAD;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_got_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_a_q     <= num1;
            fail_b_q     <= num2;
            fail_got_q   <= got;
          end
          if (last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= ST_SETTLE;
            cnt_q   <= RELOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_got   = fail_got_q;

endmodule : add_checker
`default_nettype wire
